// File: rtl/simpleuart_fifo_if.sv
// simpleuart_fifo_if: CPU data/status port and simpleuart data port bundled as one bus
interface simpleuart_fifo_if;
    logic        dat_we;
    logic        dat_re;
    logic [31:0] dat_di;
    logic [31:0] dat_do;
    logic        dat_wait;
    logic        stat_we;
    logic [31:0] stat_do;
    logic        uart_dat_we;
    logic [31:0] uart_dat_di;
    logic        uart_dat_wait;
    logic        uart_dat_re;
    logic [31:0] uart_dat_do;

    modport slave (
        input  dat_we, dat_re, dat_di, stat_we, uart_dat_wait, uart_dat_do,
        output dat_do, dat_wait, stat_do, uart_dat_we, uart_dat_di, uart_dat_re
    );

    modport master (
        output dat_we, dat_re, dat_di, stat_we, uart_dat_wait, uart_dat_do,
        input  dat_do, dat_wait, stat_do, uart_dat_we, uart_dat_di, uart_dat_re
    );
endinterface

// File: rtl/simpleuart_fifo.sv
// simpleuart_fifo: TX/RX byte FIFOs between the CPU iomem data register and simpleuart
module simpleuart_fifo #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              resetn,
    simpleuart_fifo_if.slave  bus
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;

    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [TAW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [RAW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, flush_tx, flush_rx;
    logic unused;

    // Full/empty come only from the registered counts, so a same-cycle pop never unblocks a push
    assign tx_full  = tx_cnt_q == TCW'(TX_DEPTH);
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == RCW'(RX_DEPTH);
    assign rx_empty = rx_cnt_q == '0;

    assign tx_push  = bus.dat_we && !tx_full;
    assign tx_pop   = bus.uart_dat_we && !bus.uart_dat_wait;
    assign rx_push  = bus.uart_dat_re;
    assign rx_pop   = bus.dat_re && !rx_empty;
    assign flush_tx = bus.stat_we && bus.dat_di[0];
    assign flush_rx = bus.stat_we && bus.dat_di[1];

    assign bus.dat_wait    = bus.dat_we && tx_full;
    assign bus.uart_dat_we = !tx_empty;
    assign bus.uart_dat_di = {24'b0, tx_mem_q[tx_rd_q]};
    assign bus.uart_dat_re = !bus.uart_dat_do[31] && !rx_full;
    assign bus.dat_do      = rx_empty ? 32'hFFFF_FFFF : {24'b0, rx_mem_q[rx_rd_q]};
    assign bus.stat_do     = {12'b0, rx_full, rx_empty, tx_full, tx_empty, 8'(rx_cnt_q), 8'(tx_cnt_q)};

    assign unused = ^{bus.dat_di[31:8], bus.uart_dat_do[30:8]};

    // Next pointers and counts; a flush overrides any push/pop on the same FIFO
    always_comb begin
        tx_wr_d  = flush_tx ? '0 : tx_wr_q + TAW'(tx_push);
        tx_rd_d  = flush_tx ? '0 : tx_rd_q + TAW'(tx_pop);
        tx_cnt_d = flush_tx ? '0 : tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
        rx_wr_d  = flush_rx ? '0 : rx_wr_q + RAW'(rx_push);
        rx_rd_d  = flush_rx ? '0 : rx_rd_q + RAW'(rx_pop);
        rx_cnt_d = flush_rx ? '0 : rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Storage arrays need no reset; only slots covered by the count are ever read
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= bus.dat_di[7:0];
        if (rx_push) rx_mem_q[rx_wr_q] <= bus.uart_dat_do[7:0];
    end
endmodule

// File: doc/simpleuart_fifo.md
# simpleuart_fifo

Byte FIFO bridge between the PicoRV32 iomem data register and the `simpleuart` data port. A TX FIFO absorbs CPU writes so the core stalls only when the FIFO is full, not once per byte. An RX FIFO polls the UART's single-byte receive buffer and drains it immediately, so back-to-back received bytes are not lost while software is busy. A status/flush register exposes fill levels and lets software empty either FIFO.

## Interface
- `TX_DEPTH`, default 16: TX FIFO entries; power of two, 2..128.
- `RX_DEPTH`, default 16: RX FIFO entries; power of two, 2..128.

- `clk` in 1: single clock; all state is on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `dat_we` in 1: CPU data write strobe; held until `dat_wait` is low.
- `dat_re` in 1: CPU data read strobe; single cycle.
- `dat_di` in 32: CPU write data. Bits [7:0] carry the TX byte. On `stat_we`, bit 0 is flush-TX and bit 1 is flush-RX.
- `dat_do` out 32: RX head byte, or all-ones when RX is empty.
- `dat_wait` out 1: stall for a CPU write; equals `dat_we && tx_full`.
- `stat_we` in 1: status register write strobe (flush).
- `stat_do` out 32: status word.
- `uart_dat_we` out 1: write strobe to UART `reg_dat_we`.
- `uart_dat_di` out 32: write data to UART `reg_dat_di`.
- `uart_dat_wait` in 1: UART write stall, from `reg_dat_wait`.
- `uart_dat_re` out 1: read strobe to UART `reg_dat_re`.
- `uart_dat_do` in 32: UART read data from `reg_dat_do`. The value is all-ones when no byte is valid, otherwise `{24'b0, byte}`.

## Operation
- Both FIFOs are register arrays with read pointer, write pointer and count. The count is `$clog2(DEPTH)+1` bits wide.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0). Both are decoded from registered count, never from same-cycle events.
- TX push
  - Condition: `dat_we && !tx_full`. It stores `dat_di[7:0]`.
  - When full, `dat_wait` is high and nothing is stored. This holds even if a pop occurs in the same cycle; the write completes the following cycle.
- TX drain
  - `uart_dat_we = !tx_empty`; `uart_dat_di = {24'b0, tx_head}`.
  - Pop when `uart_dat_we && !uart_dat_wait`.
- RX capture
  - `uart_dat_re = !uart_dat_do[31] && !rx_full`. On that cycle, push `uart_dat_do[7:0]`.
  - When RX is full, the byte stays in the UART buffer; any UART-side overrun is outside this block.
- RX read
  - `dat_do = rx_empty ? 32'hFFFF_FFFF : {24'b0, rx_head}`.
  - Pop on `dat_re && !rx_empty`. `dat_re` while empty has no effect.
- Simultaneous push and pop on one FIFO: both happen and the count is unchanged.
- Flush (`stat_we`)
  - `dat_di[0]` clears TX pointers and count; `dat_di[1]` clears RX pointers and count.
  - Flush has priority over a push or pop in the same cycle; the flushed FIFO ends empty.
  - A byte already accepted by the UART is not recalled.
- `stat_do` bit layout:
  - [7:0] tx_count
  - [15:8] rx_count
  - [16] tx_empty
  - [17] tx_full
  - [18] rx_empty
  - [19] rx_full
  - [31:20] zero
- Reset (async assert, sync-to-clk release): all pointers and counts go to 0. Array contents are don't-care.

## Timing
- All outputs are combinational from registered state and current inputs. There is no added output register.
- Output values in reset:
  - `dat_wait` = 0.
  - `uart_dat_we` = 0.
  - `uart_dat_di` = 0 in the upper bits; low byte is don't-care.
  - `uart_dat_re` = `!uart_dat_do[31]`. This is 0 while the UART is also in reset.
  - `dat_do` = all-ones.
  - `stat_do` = 32'h0005_0000.
- CPU write to `uart_dat_we` high: 1 cycle (the push is registered at the edge).
- UART byte valid to `uart_dat_re`: 0 cycles. Byte visible on `dat_do`: next cycle. The UART clears its valid flag on the same edge, so each byte is captured exactly once.
- The TX FIFO sustains one byte per UART frame; the RX FIFO accepts one byte per cycle.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 with `uart_dat_wait` low. Expect `uart_dat_we` high for three cycles presenting 0x41, 0x42, 0x43 in order, `dat_wait` never high, then tx_count=0.
- TX_DEPTH=4: hold `uart_dat_wait` high and write 5 bytes. Expect the 5th write to see `dat_wait`=1 and `stat_do`[17]=1. Release `uart_dat_wait` for one cycle: the 5th write completes the next cycle and tx_count stays 4.
- Drive `uart_dat_do`=0x0000_0055 for one cycle, then all-ones. Expect `uart_dat_re` pulse, `dat_do`=0x55 next cycle, rx_count=1. `dat_re` then gives `dat_do`=all-ones and rx_count=0.
- RX_DEPTH=4: present 5 bytes without CPU reads. Expect `uart_dat_re`=0 on the 5th while rx_full. After one `dat_re`, the 5th byte is captured on the following cycle.
- Fill TX with 3 bytes, then write `stat_we` with `dat_di`=3 in the same cycle as a CPU data write. Expect tx_count=0, rx_count=0 and `uart_dat_we`=0 next cycle.
- Assert `resetn` low mid-drain with 2 bytes queued. Expect `uart_dat_we` to drop immediately (asynchronously) and `stat_do`=32'h0005_0000.
